// File: rtl/wb_mailbox_responder.sv
// wb_mailbox_responder: Wishbone classic mailbox with M2U/U2M FIFOs, status, irq-enable and scratch registers.
module wb_mailbox_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                      core_clk,
  input  logic                      core_rstn,
  input  logic                      push,
  input  logic                      pop,
  input  logic [31:0]               din,
  output logic [31:0]               dout,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign dout    = mem[rd_ptr];
  // No bypass: a pop needs stored data, and a full FIFO only takes a push alongside a pop.
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);
  always_ff @(posedge core_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module wb_mailbox_responder #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        core_clk,
  input  logic        core_rstn,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic [31:0] m2u_data,
  output logic        m2u_valid,
  input  logic        m2u_ready,
  input  logic [31:0] u2m_data,
  input  logic        u2m_valid,
  output logic        u2m_ready,
  output logic        irq_o
);
  localparam int AW = $clog2(DEPTH);
  logic              hit, cpu_push, cpu_pop, ovf, udf;
  logic [1:0]        off;
  logic [2:0]        irq_en;
  logic [31:0]       scratch, wmask, status, rd_data, u2m_head;
  logic [AW:0]       m2u_cnt, u2m_cnt;
  logic              m2u_full, m2u_empty, u2m_full, u2m_empty;
  logic              unused;
  assign unused    = ^wb_adr_i[1:0];
  assign hit       = wb_cyc_i & wb_stb_i & (wb_adr_i[31:4] == BASE_ADR[31:4]) & !wb_ack_o;
  assign off       = wb_adr_i[3:2];
  assign cpu_push  = hit & wb_we_i & (off == 2'd0);
  assign cpu_pop   = hit & !wb_we_i & (off == 2'd0);
  assign wmask     = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign m2u_valid = !m2u_empty;
  assign u2m_ready = !u2m_full;
  wb_mailbox_fifo #(.DEPTH(DEPTH)) m2u_fifo (
    .core_clk(core_clk), .core_rstn(core_rstn),
    .push(cpu_push), .pop(m2u_ready), .din(wb_dat_i & wmask),
    .dout(m2u_data), .count(m2u_cnt), .full(m2u_full), .empty(m2u_empty)
  );
  wb_mailbox_fifo #(.DEPTH(DEPTH)) u2m_fifo (
    .core_clk(core_clk), .core_rstn(core_rstn),
    .push(u2m_valid & u2m_ready), .pop(cpu_pop), .din(u2m_data),
    .dout(u2m_head), .count(u2m_cnt), .full(u2m_full), .empty(u2m_empty)
  );
  assign status  = {8'd0, 8'(m2u_cnt), 8'(u2m_cnt), 2'd0, udf, ovf, u2m_empty, u2m_full, m2u_empty, m2u_full};
  assign rd_data = off == 2'd0 ? (u2m_empty ? 32'd0 : u2m_head) :
                   off == 2'd1 ? status :
                   off == 2'd2 ? {29'd0, irq_en} : scratch;
  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      irq_o    <= 1'b0;
      irq_en   <= '0;
      scratch  <= '0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      wb_ack_o <= hit;
      wb_dat_o <= (hit & !wb_we_i) ? rd_data : 32'd0;
      irq_o    <= (irq_en[0] & !u2m_empty) | (irq_en[1] & m2u_empty) | (irq_en[2] & (ovf | udf));
      // A user pop in the same cycle makes room, so only a truly blocked push overflows.
      if (cpu_push & m2u_full & !m2u_ready) ovf <= 1'b1;
      if (cpu_pop & u2m_empty) udf <= 1'b1;
      if (hit & wb_we_i & (off == 2'd1) & wb_sel_i[0]) begin
        if (wb_dat_i[4]) ovf <= 1'b0;
        if (wb_dat_i[5]) udf <= 1'b0;
      end
      if (hit & wb_we_i & (off == 2'd2) & wb_sel_i[0]) irq_en <= wb_dat_i[2:0];
      if (hit & wb_we_i & (off == 2'd3)) scratch <= (scratch & ~wmask) | (wb_dat_i & wmask);
    end
  end
endmodule

// File: tb/tb_wb_mailbox_responder.sv
// tb_wb_mailbox_responder: directed bench with a read-data scoreboard for the Wishbone mailbox.
module tb_wb_mailbox_responder;
  localparam logic [31:0] B = 32'h3000_0000;
  logic        core_clk = 0, core_rstn;
  logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o, m2u_data, u2m_data;
  logic        m2u_valid, m2u_ready, u2m_valid, u2m_ready, irq_o;
  int          checks = 0, errors = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic [31:0] w [6];

  always #5 core_clk = ~core_clk;

  wb_mailbox_responder #(.BASE_ADR(B), .DEPTH(4)) dut (
    .core_clk(core_clk), .core_rstn(core_rstn),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
    .m2u_data(m2u_data), .m2u_valid(m2u_valid), .m2u_ready(m2u_ready),
    .u2m_data(u2m_data), .u2m_valid(u2m_valid), .u2m_ready(u2m_ready), .irq_o(irq_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic pop, input logic [31:0] exp, input string tag);
    int n;
    if (!we) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    @(negedge core_clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; m2u_ready = pop;
    n = 0;
    do begin
      @(negedge core_clk);
      m2u_ready = 0;
      n++;
    end while (!wb_ack_o && n < 4);
    chk({tag, " ack latency"}, n, 1);
    if (!we) chk(tag_q.pop_front(), wb_ack_o ? wb_dat_o : 32'hx, exp_q.pop_front());
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
  endtask

  task automatic miss(input logic we, input logic [31:0] adr, input string tag);
    logic seen;
    seen = 0;
    @(negedge core_clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = 32'h5555_AAAA; wb_sel_i = 4'hF;
    repeat (4) begin
      @(negedge core_clk);
      seen |= wb_ack_o;
    end
    chk(tag, seen, 0);
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
  endtask

  task automatic user_pop();
    @(negedge core_clk); m2u_ready = 1;
    @(negedge core_clk); m2u_ready = 0;
  endtask

  task automatic user_push(input logic [31:0] d);
    @(negedge core_clk); u2m_valid = 1; u2m_data = d;
    @(negedge core_clk); u2m_valid = 0;
  endtask

  initial begin
    core_rstn = 0; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_sel_i = 0;
    wb_adr_i = 0; wb_dat_i = 0; m2u_ready = 0; u2m_data = 0; u2m_valid = 0;
    repeat (3) @(negedge core_clk);
    chk("rst ack", wb_ack_o, 0);
    chk("rst dat", wb_dat_o, 0);
    chk("rst irq", irq_o, 0);
    chk("rst m2u_valid", m2u_valid, 0);
    chk("rst u2m_ready", u2m_ready, 1);
    core_rstn = 1;
    bus(0, B + 4, 0, 4'hF, 0, 32'h0000_000A, "status after reset");
    bus(0, B + 8, 0, 4'hF, 0, 32'h0, "irq_en after reset");
    bus(0, B + 12, 0, 4'hF, 0, 32'h0, "scratch after reset");
    bus(1, B + 12, 32'hDEAD_BEEF, 4'b1001, 0, 0, "scratch write");
    bus(0, B + 12, 0, 4'hF, 0, 32'hDE00_00EF, "scratch byte enables");

    bus(1, B, 32'h1122_3344, 4'b0101, 0, 0, "data masked write");
    chk("m2u_valid after write", m2u_valid, 1);
    chk("m2u_data masked", m2u_data, 32'h0022_0044);
    user_pop();
    chk("m2u_valid after pop", m2u_valid, 0);
    bus(0, B + 4, 0, 4'hF, 0, 32'h0000_000A, "status m2u empty again");

    for (int k = 0; k < 6; k++) w[k] = 32'hA000_0000 + k;
    for (int k = 0; k < 5; k++) bus(1, B, w[k], 4'hF, 0, 0, "fill m2u");
    bus(0, B + 4, 0, 4'hF, 0, 32'h0004_0019, "status full overflow");
    bus(1, B + 4, 32'h10, 4'h1, 0, 0, "clear overflow");
    bus(0, B + 4, 0, 4'hF, 0, 32'h0004_0009, "status overflow cleared");
    bus(1, B, w[5], 4'hF, 1, 0, "push with pop when full");
    bus(0, B + 4, 0, 4'hF, 0, 32'h0004_0009, "status full push+pop");
    foreach (w[k]) if (k != 0 && k != 4) begin
      chk("m2u order", m2u_data, w[k]);
      user_pop();
    end
    chk("m2u drained", m2u_valid, 0);

    bus(1, B + 8, 32'h1, 4'h1, 0, 0, "irq_en write");
    user_push(32'hCAFE_F00D);
    chk("irq before latency", irq_o, 0);
    @(negedge core_clk);
    chk("irq u2m non-empty", irq_o, 1);
    bus(0, B, 0, 4'hF, 0, 32'hCAFE_F00D, "data read pop");
    @(negedge core_clk);
    chk("irq falls", irq_o, 0);
    bus(0, B, 0, 4'hF, 0, 32'h0, "underflow read");
    bus(0, B + 4, 0, 4'hF, 0, 32'h0000_002A, "status underflow");

    for (int k = 0; k < 4; k++) user_push(32'hB000_0000 + k);
    chk("u2m_ready when full", u2m_ready, 0);
    bus(0, B + 4, 0, 4'hF, 0, 32'h0000_0426, "status u2m full");
    bus(1, B, 32'h7777_8888, 4'hF, 0, 0, "m2u before reset");
    chk("irq before reset", irq_o, 1);

    @(negedge core_clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = B; core_rstn = 0;
    @(negedge core_clk);
    chk("reset drops ack", wb_ack_o, 0);
    chk("reset flush m2u", m2u_valid, 0);
    chk("reset flush u2m", u2m_ready, 1);
    chk("reset irq", irq_o, 0);
    wb_cyc_i = 0; wb_stb_i = 0; core_rstn = 1;
    bus(0, B + 4, 0, 4'hF, 0, 32'h0000_000A, "status after mid reset");
    bus(0, B + 12, 0, 4'hF, 0, 32'h0, "scratch after mid reset");

    miss(1, B + 32'h10, "miss write no ack");
    miss(0, B + 32'h1C, "miss read no ack");
    chk("miss no push", m2u_valid, 0);
    bus(0, B + 4, 0, 4'hF, 0, 32'h0000_000A, "status after miss");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_mailbox_responder.md
Name: wb_mailbox_responder

Overview:
- Wishbone classic responder on the user-project side of the exported management Wishbone bus (the mprj_* initiator).
- Provides two 32-bit FIFOs: CPU-to-user (M2U) and user-to-CPU (U2M), plus status, interrupt-enable and scratch registers.
- Drives a level interrupt that is wired back into one of the user IRQ inputs.

Parameters:
- BASE_ADR, 32'h3000_0000: base address; the block decodes wb_adr_i[31:4] == BASE_ADR[31:4].
- DEPTH, 4: entries per FIFO; power of two, range 2..128.

Ports:
- core_clk  in  1  single clock.
- core_rstn  in  1  synchronous active-low reset.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte lane selects.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_ack_o  out  1  acknowledge.
- wb_dat_o  out  32  read data.
- m2u_data  out  32  head of the M2U FIFO.
- m2u_valid  out  1  M2U FIFO is non-empty.
- m2u_ready  in  1  user pops M2U when m2u_valid & m2u_ready.
- u2m_data  in  32  user push data.
- u2m_valid  in  1  user push request.
- u2m_ready  out  1  U2M FIFO is not full.
- irq_o  out  1  level interrupt.

Behaviour:
- Interface: one clock, core_clk; reset core_rstn is synchronous and active-low.
- Reset values: wb_ack_o=0, wb_dat_o=0, irq_o=0, both FIFOs empty, m2u_valid=0, u2m_ready=1, IRQ_EN=0, SCRATCH=0, sticky flags=0.
- A reset mid-transaction drops ack and flushes both FIFOs; the pending access is not completed.
- Hit condition: wb_cyc_i & wb_stb_i & address match & !wb_ack_o.
- On a hit, wb_ack_o=1 on the next cycle for exactly one cycle. Read data is registered and valid with ack.
- Latency is 1 cycle. Back-to-back strobes are therefore acked at most every other cycle.
- A non-matching address gets no ack (the bus timeout is handled elsewhere) and no side effects.
- Side effects occur once per access, in the hit cycle.
- Register map, offset wb_adr_i[3:2]:
  - 0x0 DATA:
    - Write pushes {lanes masked by wb_sel_i, unselected bytes = 0} into M2U.
    - Read pops U2M and returns the head.
  - 0x4 STATUS, read-only except the W1C bits:
    - [0] m2u_full, [1] m2u_empty, [2] u2m_full, [3] u2m_empty.
    - [4] overflow (sticky), [5] underflow (sticky).
    - [15:8] u2m count, [23:16] m2u count, others 0.
    - Writing 1 to [4] or [5] with wb_sel_i[0]=1 clears that bit.
  - 0x8 IRQ_EN[2:0]:
    - [0] enables U2M non-empty, [1] enables M2U empty, [2] enables error.
    - Byte-enabled write; bits [31:3] read 0.
  - 0xC SCRATCH: 32-bit R/W, byte-enabled.
- FIFO rules (both FIFOs):
  - Circular buffer with log2(DEPTH)-bit read/write pointers plus a count of log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
  - A push is accepted if !full, or if a pop occurs in the same cycle (a full FIFO with simultaneous push and pop keeps count=DEPTH).
  - A pop on an empty FIFO has no effect, even with a simultaneous push; there is no bypass.
  - Count updates: +1 for push only, -1 for pop only, unchanged for both.
- Error cases:
  - DATA write while M2U is full and no user pop in the same cycle: data is dropped and overflow is set.
  - DATA read while U2M is empty: returns 0 and underflow is set. A same-cycle user push is still accepted.
  - A user push while U2M is full is ignored by the handshake (u2m_ready=0) and is not an error.
- m2u_data is the combinational head of the M2U FIFO. m2u_valid = !m2u_empty. u2m_ready = !u2m_full.
- irq_o is registered, one cycle after the state change: (en[0] & !u2m_empty) | (en[1] & m2u_empty) | (en[2] & (overflow | underflow)).
- Status reads return the state from before that cycle's updates.

Test Plan:
- Reset then read 0x4 -> ack on cycle 2; data 32'h0000_000A (both empty). Read 0x8 and 0xC -> 0.
- Write 0x11223344 to 0x0 with sel=4'b0101 -> m2u_valid=1, m2u_data=0x00220044. Pulse m2u_ready -> m2u_valid=0, STATUS[1]=1.
- Push 5 words (DEPTH=4) to 0x0 with m2u_ready=0 -> STATUS m2u count=4, [0]=1, [4]=1; popped data equals the first 4 words in order. Write 0x10 to 0x4 -> [4]=0.
- With M2U full, write DATA while m2u_ready=1 in the same cycle -> write accepted, count stays 4, overflow stays 0.
- Set IRQ_EN=1; user pushes 0xCAFEF00D -> irq_o=1 one cycle later. CPU reads 0x0 -> 0xCAFEF00D and irq_o falls. Read again -> 0, STATUS[5]=1.
- Assert core_rstn=0 while an ack is pending and both FIFOs hold data -> next cycle wb_ack_o=0, FIFOs empty, irq_o=0. Access to BASE_ADR+0x10 -> no ack and no state change.
